// File: rtl/wb_pkg.sv
// Shared types and sizing for the writeback arbiter slice.
package wb_pkg;

    localparam int unsigned WB_ADDRESS_WIDTH = 5;
    localparam int unsigned WB_DATA_WIDTH    = 32;
    localparam int unsigned WB_FIFO_DEPTH    = 2;
    localparam int unsigned WB_COUNT_WIDTH   = $clog2(WB_FIFO_DEPTH) + 1;

    // Occupancy counter must hold the value DEPTH itself, hence the extra bit.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic                        valid;
        logic [WB_ADDRESS_WIDTH-1:0] rd;
        logic [WB_DATA_WIDTH-1:0]    data;
    } wb_entry_t;

    // Source chosen for the next registered register-file write.
    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_ALU,
        SEL_FIFO,
        SEL_BYPASS
    } wb_sel_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of ALU, long-latency and register-file write-port signals.
interface wb_arbiter_if
    import wb_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = WB_ADDRESS_WIDTH,
    parameter int unsigned DATA_WIDTH    = WB_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH    = WB_FIFO_DEPTH
) ();

    logic                         alu_valid;
    logic [ADDRESS_WIDTH-1:0]     alu_rd;
    logic [DATA_WIDTH-1:0]        alu_data;
    logic                         mem_valid;
    logic                         mem_ready;
    logic [ADDRESS_WIDTH-1:0]     mem_rd;
    logic [DATA_WIDTH-1:0]        mem_data;
    logic                         we3;
    logic [ADDRESS_WIDTH-1:0]     ad3;
    logic [DATA_WIDTH-1:0]        wd3;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;

    // Result producers and register-file side.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready, we3, ad3, wd3, fifo_count
    );

    // The arbiter itself.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready, we3, ad3, wd3, fifo_count
    );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of long-latency results with per-entry rd-match squash.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = WB_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push_i,
    input  wb_entry_t                   push_entry_i,
    input  logic                        pop_i,
    input  logic                        squash_i,
    input  logic [WB_ADDRESS_WIDTH-1:0] squash_rd_i,
    output wb_entry_t                   head_o,
    output logic [$clog2(DEPTH):0]      count_o
);

    localparam int unsigned     PW   = $clog2(DEPTH);
    localparam int unsigned     CW   = count_width(DEPTH);
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);

    wb_entry_t       mem_q [DEPTH];
    wb_entry_t       mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            pop_ok;
    logic            push_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q != FULL) || pop_ok);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next storage/pointer state: squash first, then write the free slot.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (squash_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (mem_q[i].rd == squash_rd_i) begin
                    mem_d[i].valid = 1'b0;
                end
            end
        end
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_entry_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // State registers; reset drops every queued entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and long-latency results onto one register write port.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = WB_ADDRESS_WIDTH,
    parameter int unsigned DATA_WIDTH    = WB_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH    = WB_FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_arbiter_if.slave   bus
);

    localparam int unsigned   CW   = count_width(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [CW-1:0]            count;
    wb_entry_t                head;
    wb_entry_t                push_entry;
    wb_sel_e                  sel;
    logic                     alu_wr;
    logic                     mem_ready;
    logic                     mem_live;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;

    logic                     we3_q, we3_d;
    logic [ADDRESS_WIDTH-1:0] ad3_q, ad3_d;
    logic [DATA_WIDTH-1:0]    wd3_q, wd3_d;

    assign alu_wr     = bus.alu_valid && (bus.alu_rd != '0);
    assign mem_ready  = (count != FULL);
    // Accepted beats to x0 complete the handshake but go nowhere.
    assign mem_live   = bus.mem_valid && mem_ready && (bus.mem_rd != '0);
    assign fifo_empty = (count == '0);

    // Source priority: ALU, then FIFO head, then direct bypass of an accepted beat.
    always_comb begin
        sel = SEL_NONE;
        if (alu_wr) begin
            sel = SEL_ALU;
        end else if (!fifo_empty) begin
            sel = SEL_FIFO;
        end else if (mem_live) begin
            sel = SEL_BYPASS;
        end
    end

    // An accepted beat hitting the same register as this cycle's ALU write is older, so dropped.
    assign push = mem_live && (sel != SEL_BYPASS) &&
                  !(alu_wr && (bus.mem_rd == bus.alu_rd));
    assign pop  = (sel == SEL_FIFO);
    assign push_entry = '{valid: 1'b1, rd: bus.mem_rd, data: bus.mem_data};

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .squash_i     (alu_wr),
        .squash_rd_i  (bus.alu_rd),
        .head_o       (head),
        .count_o      (count)
    );

    // Next write-port values; address/data hold when nothing is written.
    always_comb begin
        we3_d = 1'b0;
        ad3_d = ad3_q;
        wd3_d = wd3_q;
        case (sel)
            SEL_ALU: begin
                we3_d = 1'b1;
                ad3_d = bus.alu_rd;
                wd3_d = bus.alu_data;
            end
            SEL_FIFO: begin
                we3_d = head.valid;
                if (head.valid) begin
                    ad3_d = head.rd;
                    wd3_d = head.data;
                end
            end
            SEL_BYPASS: begin
                we3_d = 1'b1;
                ad3_d = bus.mem_rd;
                wd3_d = bus.mem_data;
            end
            default: begin
                we3_d = 1'b0;
            end
        endcase
    end

    // Registered register-file write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3_q <= 1'b0;
            ad3_q <= '0;
            wd3_q <= '0;
        end else begin
            we3_q <= we3_d;
            ad3_q <= ad3_d;
            wd3_q <= wd3_d;
        end
    end

    assign bus.mem_ready  = mem_ready;
    assign bus.we3        = we3_q;
    assign bus.ad3        = ad3_q;
    assign bus.wd3        = wd3_q;
    assign bus.fifo_count = count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed scenarios plus randomized traffic.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    wb_arbiter_if #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH)
    ) bus ();

    wb_arbiter #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: list of outstanding long-latency results in arrival order.
    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        bit            live;
    } pend_t;

    // Expected DUT state one cycle after each applied input set.
    typedef struct {
        bit            we;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        int unsigned   cnt;
        bit            rdy;
    } exp_t;

    pend_t pend[$];
    exp_t  expq[$];
    int    checks = 0;
    int    errors = 0;
    bit    done   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs and predict the write that results.
    task automatic apply(input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                         input bit mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                         output bit accepted);
        exp_t  e;
        pend_t h;
        bit    acc;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_rd    = mrd;
        bus.mem_data  = md;
        e.we   = 1'b0;
        e.rd   = '0;
        e.data = '0;
        acc      = mv && (pend.size() < DEPTH);
        accepted = acc;
        if (av && ard != 0) begin
            e.we   = 1'b1;
            e.rd   = ard;
            e.data = ad;
            foreach (pend[i]) if (pend[i].rd == ard) pend[i].live = 1'b0;
            if (acc && mrd != 0 && mrd != ard) pend.push_back('{rd: mrd, data: md, live: 1'b1});
        end else if (pend.size() != 0) begin
            h = pend.pop_front();
            if (h.live) begin
                e.we   = 1'b1;
                e.rd   = h.rd;
                e.data = h.data;
            end
            if (acc && mrd != 0) pend.push_back('{rd: mrd, data: md, live: 1'b1});
        end else if (acc && mrd != 0) begin
            e.we   = 1'b1;
            e.rd   = mrd;
            e.data = md;
        end
        e.cnt = pend.size();
        e.rdy = (pend.size() < DEPTH);
        expq.push_back(e);
    endtask

    task automatic step(input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                        input bit mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                        output bit accepted);
        @(negedge clk);
        apply(av, ard, ad, mv, mrd, md, accepted);
    endtask

    task automatic idle(input int unsigned n);
        bit a;
        repeat (n) step(1'b0, '0, '0, 1'b0, '0, '0, a);
    endtask

    // Asynchronous reset mid-low-phase; queued entries are forgotten by the model too.
    task automatic do_reset(input int unsigned cycles);
        bit a;
        @(negedge clk);
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        pend.delete();
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
        apply(1'b0, '0, '0, 1'b0, '0, '0, a);
    endtask

    // Stimulus
    initial begin : driver
        bit            a;
        bit            av;
        bit            mv;
        bit            acc;
        logic [AW-1:0] ard;
        logic [AW-1:0] mrd;
        logic [DW-1:0] ad;
        logic [DW-1:0] md;

        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_rd    = '0;
        bus.mem_data  = '0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        apply(1'b0, '0, '0, 1'b0, '0, '0, a);
        idle(2);

        // ALU only, including x0
        step(1'b1, 5'd3, 32'h11, 1'b0, '0, '0, a);
        idle(1);
        step(1'b1, 5'd0, 32'h22, 1'b0, '0, '0, a);
        idle(1);

        // Simultaneous ALU and long-latency beat
        step(1'b1, 5'd4, 32'hA, 1'b1, 5'd7, 32'hB, a);
        idle(2);

        // Fill the FIFO behind continuous ALU traffic, then drain in order
        step(1'b1, 5'd1, 32'h100, 1'b1, 5'd8, 32'h88, a);
        step(1'b1, 5'd1, 32'h101, 1'b1, 5'd9, 32'h99, a);
        step(1'b1, 5'd1, 32'h102, 1'b1, 5'd10, 32'hAA, a);
        idle(3);

        // Squash a queued entry with a younger ALU write
        step(1'b1, 5'd2, 32'h22, 1'b1, 5'd5, 32'h55, a);
        step(1'b1, 5'd5, 32'h66, 1'b0, '0, '0, a);
        idle(2);

        // Same-cycle squash of an accepted beat, and an x0 beat
        step(1'b1, 5'd6, 32'h60, 1'b1, 5'd6, 32'h61, a);
        step(1'b0, '0, '0, 1'b1, 5'd0, 32'h70, a);
        idle(1);

        // Reset with two entries queued
        step(1'b1, 5'd1, 32'h1, 1'b1, 5'd12, 32'hC, a);
        step(1'b1, 5'd1, 32'h2, 1'b1, 5'd13, 32'hD, a);
        do_reset(2);
        idle(4);

        // Randomized traffic with a small register range to provoke collisions
        mv  = 1'b0;
        acc = 1'b0;
        mrd = '0;
        md  = '0;
        repeat (400) begin
            av  = ($urandom_range(0, 9) < 6);
            ard = AW'($urandom_range(0, 7));
            ad  = $urandom;
            if (!mv || acc) begin
                mv  = ($urandom_range(0, 9) < 5);
                mrd = AW'($urandom_range(0, 7));
                md  = $urandom;
            end
            step(av, ard, ad, mv, mrd, md, acc);
        end
        idle(8);

        @(posedge clk);
        #2;
        done = 1'b1;
    end

    // Monitor: compares the DUT against the scoreboard one cycle after each input set.
    initial begin : monitor
        int unsigned cycles;
        exp_t        e;
        cycles = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            cycles++;
            if (cycles > 20000) begin
                errors++;
                $display("FAIL timeout: got %0d cycles, expected completion", cycles);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
            if (!rst_n) begin
                chk("reset_we3", 64'(bus.we3), 64'(0));
                chk("reset_fifo_count", 64'(bus.fifo_count), 64'(0));
                chk("reset_mem_ready", 64'(bus.mem_ready), 64'(1));
            end else if (done) begin
                chk("leftover_expectations", 64'(expq.size()), 64'(0));
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end else if (expq.size() == 0) begin
                chk("expectation_available", 64'(0), 64'(1));
            end else begin
                e = expq.pop_front();
                chk("we3", 64'(bus.we3), 64'(e.we));
                if (e.we) begin
                    chk("ad3", 64'(bus.ad3), 64'(e.rd));
                    chk("wd3", 64'(bus.wd3), 64'(e.data));
                end
                chk("fifo_count", 64'(bus.fifo_count), 64'(e.cnt));
                chk("mem_ready", 64'(bus.mem_ready), 64'(e.rdy));
            end
        end
    end

endmodule
